// File: rtl/parity_check_odd_rx.sv
// -----------------------------------------------------------------------------
// parity_check_odd_rx
//
// Serial receiver for a six-bit frame with odd parity:
//   start(0), a, b, c, p, stop(1)
// The receiver takes one bit for each din_valid strobe. Strobes may be spaced
// any number of cycles apart, and nothing times out while din_valid is low.
// When the stop bit is sampled, the three data bits and the two error flags
// are registered. They become visible in the following cycle together with a
// one-cycle data_valid pulse.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   din         in   1  serial line (idle high), sampled only when din_valid=1
//   din_valid   in   1  bit strobe
//   cnt_clr     in   1  synchronous clear of err_count (clear beats increment)
//   data_out    out  3  last received {a,b,c}; a is the MSB; held between frames
//   data_valid  out  1  one-cycle pulse per completed frame
//   parity_err  out  1  ~(a^b^c^p); forced to 0 while data_valid=0
//   frame_err   out  1  ~stop; forced to 0 while data_valid=0
//   err_count   out  8  saturating count of frames with any error
//
// Configuration
//   PARITY_ERR_CNT_EN  when defined, adds the err_count register, its
//                      saturation logic and the cnt_clr input handling.
//                      When undefined, err_count is tied to 0 and cnt_clr
//                      is ignored.
// -----------------------------------------------------------------------------
module parity_check_odd_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       cnt_clr,
  output logic [2:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic [1:0] LAST_DATA_BIT = 2'd2;

  // Frame-assembly state
  state_e     state_q,      state_d;
  logic [1:0] bit_cnt_q,    bit_cnt_d;
  logic [2:0] shift_q,      shift_d;
  logic       par_q,        par_d;

  // Registered outputs
  logic [2:0] data_out_q,   data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q,  frame_err_d;

  // Strobe sampling the stop bit: the frame finishes on this edge.
  logic       frame_done;
  // Parity or stop error on the frame finishing on this edge.
  logic       frame_bad;

  logic       parity_bad_now;
  logic       stop_bad_now;

  // Odd parity holds when a^b^c^p is 1, so a result of 0 is an error.
  assign parity_bad_now = ~(^{shift_q, par_q});
  assign stop_bad_now   = ~din;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here first gets a default. A path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_done   = 1'b0;
    frame_bad    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          // A strobe with din high is idle line and does not start a frame.
          if (!din) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end

        DATA: begin
          // Shift left so the first data bit (a) ends up in the MSB.
          shift_d = {shift_q[1:0], din};
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d   = PAR;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 2'd1;
          end
        end

        PAR: begin
          par_d   = din;
          state_d = STOP;
        end

        STOP: begin
          // The frame finishes whatever the stop bit is. A bad stop bit is
          // reported through frame_err, not by discarding the frame.
          frame_done   = 1'b1;
          frame_bad    = parity_bad_now | stop_bad_now;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = parity_bad_now;
          frame_err_d  = stop_bad_now;
          state_d      = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset clears every flop, including the shift register and
    // data_out. A frame interrupted by reset then leaves nothing behind.
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, whatever order the statements appear in.
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    // The clear wins over an increment on the same edge. A frame with both
    // errors still counts only once.
    if (cnt_clr) begin
      err_count_d = '0;
    end else if (frame_done && frame_bad && (err_count_q != ERR_CNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  // Counter not built: the output is constant and these inputs are
  // deliberately unused.
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = cnt_clr ^ frame_done ^ frame_bad;
  assign err_count         = 8'd0;
`endif

endmodule
